mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8: data width of each mux input and of the output.
REQ-002 SHALL have parameter MAX_HOLD, default 15: maximum grant duration in cycles, used only when the timeout feature is compiled in.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 4 bits: req[i] high = requester i wants the shared 4:1 datapath.
REQ-006 SHALL have port rel, input, 1 bit: release strobe from the current owner; ignored when no grant is active.
REQ-007 SHALL have port in, input, 4*DW bits: requester i data at in[i*DW +: DW].
REQ-008 SHALL have port gnt, output, 4 bits: registered one-hot grant, or all zeros.
REQ-009 SHALL have port sel, output, 2 bits: registered binary index of the owner; drives the 4:1 select.
REQ-010 SHALL have port busy, output, 1 bit: registered; high while in GRANT.
REQ-011 SHALL have port out, output, DW bits: in[sel*DW +: DW] when busy is high, else 0; combinational from registered sel and busy.

Function
REQ-012 SHALL implement two states: IDLE (gnt=0, busy=0) and GRANT (gnt one-hot, busy=1).
REQ-013 SHALL keep a 2-bit priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-014 In IDLE, when req is nonzero at a clock edge, SHALL grant the first requester set in search order on the next cycle. Latency is 1 cycle from req to gnt. sel SHALL be loaded with the same index.
REQ-015 On every new grant to index k, SHALL set ptr = k+1 mod 4 (3 wraps to 0).
REQ-016 In GRANT, SHALL hold gnt and sel stable until a release condition occurs: rel=1, or req[sel]=0.
REQ-017 On a release condition, if any other req bit is set (excluding sel), SHALL hand off directly to the next winner in search order on the following cycle, with no idle cycle.
REQ-018 On a release condition with no other requester, SHALL return to IDLE on the following cycle.
REQ-019 If rel=1 and req[sel] is still 1 with no other requesters, SHALL go to IDLE. A new grant to the same requester is then possible one cycle later.
REQ-020 SHALL never assert more than one gnt bit, and sel SHALL always equal the index of the set gnt bit when busy=1.
REQ-021 When busy=0, sel SHALL retain its last value and out SHALL be 0.
REQ-022 Changes to req bits other than the owner's during GRANT SHALL NOT affect gnt.

Reset
REQ-023 When rst=1 at a clock edge, SHALL force gnt=0, sel=2'b00, busy=0, ptr=2'b00, hold counter=0, and state=IDLE, regardless of state or inputs.
REQ-024 Reset asserted mid-grant SHALL drop the grant on the next edge; after reset deassertion, arbitration SHALL restart with requester 0 highest priority.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN, when defined, SHALL add a hold counter. The counter clears on each new grant and increments each GRANT cycle. When the counter reaches MAX_HOLD, the grant SHALL be treated as a release condition (REQ-017/018) on that edge.
REQ-026 Without ARB_TIMEOUT_EN, there SHALL be no counter logic, and a grant SHALL be held indefinitely until rel=1 or req[sel]=0.

Verification
REQ-027 Reset, then req=4'b1111 held, with rel pulsed once per grant -> gnt sequence 0001, 0010, 0100, 1000, 0001; sel sequence 0, 1, 2, 3, 0.
REQ-028 IDLE, req=4'b0100 at edge N -> gnt=0100, sel=2, busy=1 at N+1; with in[2*DW +: DW]=8'hA5, out=8'hA5.
REQ-029 Owner 1, req=4'b1010, rel=1 -> next cycle gnt=1000 with no IDLE cycle; then rel with req=4'b0000 -> IDLE, gnt=0, out=0.
REQ-030 Owner 2, rst=1 for one edge -> gnt=0, sel=0, busy=0; then req=4'b1100 -> gnt=0100, since ptr was reset to 0.
REQ-031 With ARB_TIMEOUT_EN, MAX_HOLD=3, req=4'b0011 held and rel=0 -> requester 0 is granted for 4 cycles (counter values 0 to 3), then gnt=0010.
REQ-032 Owner 0, req[0] drops while req=4'b0000 -> next cycle IDLE, busy=0, sel held at 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of signals between four requesters and the round-robin 4:1 datapath arbiter.
//   req  : per-requester request bits (requester i wants the datapath)
//   rel  : release strobe from the current owner
//   in   : packed requester data, requester i at in[i*DW +: DW]
//   gnt  : registered one-hot grant (all zeros when idle)
//   sel  : registered binary index of the owner
//   busy : registered, high while a grant is active
//   out  : selected data while busy, zero otherwise
// The arbiter connects through the slave modport; requesters use the master modport.
interface mux4_rr_arbiter_if #(
    parameter int unsigned DW = 8
);
    logic [3:0]      req;
    logic            rel;
    logic [4*DW-1:0] in;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            busy;
    logic [DW-1:0]   out;

    modport master (
        output req,
        output rel,
        output in,
        input  gnt,
        input  sel,
        input  busy,
        input  out
    );

    modport slave (
        input  req,
        input  rel,
        input  in,
        output gnt,
        output sel,
        output busy,
        output out
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 datapath mux.
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport of mux4_rr_arbiter_if (req/rel/in in, gnt/sel/busy/out out)
// An owner keeps the grant until it pulses rel or drops its req bit; on release the next
// requester in rotating priority order takes over on the following cycle without an idle
// cycle. The priority pointer moves to one past each newly granted index.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that forces a release once a grant
// has been held for MAX_HOLD+1 cycles. Without it a grant is held indefinitely.
module mux4_rr_arbiter #(
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_HOLD = 15
) (
    input logic                clk,
    input logic                rst,
    mux4_rr_arbiter_if.slave   bus
);

    if (DW < 1 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("mux4_rr_arbiter: DW and MAX_HOLD must both be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;

    logic [3:0] search_req;
    logic       found;
    logic [1:0] win;
    logic       timeout;
    logic       release_cond;
    logic       new_grant;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    logic [CntW-1:0] cnt_q;

    // Counts cycles spent by the current owner; the value MAX_HOLD marks the final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (new_grant) begin
            cnt_q <= '0;
        end else if (state_q == StGrant && cnt_q != CntW'(MAX_HOLD)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StGrant) && (cnt_q == CntW'(MAX_HOLD));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;

        // The current owner is excluded so a release always moves the grant elsewhere.
        search_req = (state_q == StGrant) ? (bus.req & ~(4'b0001 << sel_q)) : bus.req;

        // Scan from the farthest offset back to ptr so the nearest requester wins.
        found = 1'b0;
        win   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (search_req[ptr_q + 2'(i)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(i);
            end
        end

        release_cond = bus.rel || !bus.req[sel_q] || timeout;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    new_grant = 1'b1;
                end
            end
            StGrant: begin
                if (release_cond) begin
                    if (found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase

        if (new_grant) begin
            state_d = StGrant;
            gnt_d   = 4'b0001 << win;
            sel_d   = win;
            ptr_d   = win + 2'd1;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = (state_q == StGrant);
    assign bus.out  = (state_q == StGrant) ? bus.in[32'(sel_q) * DW +: DW] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int unsigned DW       = 8;
    localparam int unsigned MAX_HOLD = 3;
    localparam logic [31:0] IN_WORD  = 32'hD3A5_5C1E;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard entries: {gnt[3:0], sel[1:0], busy, out[7:0]}
    logic [14:0] sb[$];
    logic [14:0] got;
    logic [14:0] want;
    int n_total = 0;
    int n_pass  = 0;

    // Reference model state for the random scenario
    logic       m_busy;
    logic [1:0] m_sel;
    int         m_ptr;
    int         m_hold;

    function automatic logic [14:0] expv(logic [3:0] g, logic [1:0] s, logic b);
        logic [31:0] w;
        logic [7:0]  d;
        w = IN_WORD;
        d = b ? w[32'(s) * 8 +: 8] : 8'h00;
        return {g, s, b, d};
    endfunction

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic r, logic [3:0] q, logic l);
        rst     = r;
        bus.req = q;
        bus.rel = l;
    endtask

    task automatic test_reset();
        // Reset dominates active requests
        drive(1'b1, 4'b1111, 1'b1);
        sb.push_back(expv(4'b0000, 2'd0, 1'b0));
        step();
        drive(1'b0, 4'b0000, 1'b0);
        sb.push_back(expv(4'b0000, 2'd0, 1'b0));
        step();
        for (int i = 0; i < 2; i++) begin
            if (i == 1) step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL reset[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] reqs[7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic       rels[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] g[7]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0000};
        logic [1:0] s[7]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, reqs[i], rels[i]);
            sb.push_back(expv(g[i], s[i], g[i] != 4'b0000));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL rotation[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        // Others toggling mid-grant must not disturb the owner; sel is kept after idle
        logic [3:0] reqs[3] = '{4'b0100, 4'b1101, 4'b0000};
        logic [3:0] g[3]    = '{4'b0100, 4'b0100, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, reqs[i], 1'b0);
            sb.push_back(expv(g[i], 2'd2, g[i] != 4'b0000));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL single[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_handoff();
        logic       rsts[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] reqs[4] = '{4'b0000, 4'b0010, 4'b1010, 4'b0000};
        logic       rels[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] g[4]    = '{4'b0000, 4'b0010, 4'b1000, 4'b0000};
        logic [1:0] s[4]    = '{2'd0, 2'd1, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            drive(rsts[i], reqs[i], rels[i]);
            sb.push_back(expv(g[i], s[i], g[i] != 4'b0000));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL handoff[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_rel_same();
        // ptr starts at 0 after the previous scenario
        logic [3:0] reqs[7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic       rels[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] g[7]    = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic [1:0] s[7]    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, reqs[i], rels[i]);
            sb.push_back(expv(g[i], s[i], g[i] != 4'b0000));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL rel_same[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        // Without the pointer reset the 1100 request would go to requester 3
        logic       rsts[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] reqs[5] = '{4'b0000, 4'b0100, 4'b0100, 4'b1100, 4'b0000};
        logic [3:0] g[5]    = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
        logic [1:0] s[5]    = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd2};
        for (int i = 0; i < 5; i++) begin
            drive(rsts[i], reqs[i], 1'b0);
            sb.push_back(expv(g[i], s[i], g[i] != 4'b0000));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL mid_reset[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        drive(1'b1, 4'b0000, 1'b0);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'b0011, 1'b0);
            // Timeout build: 4 cycles each (hold count 0..MAX_HOLD); otherwise held forever
            if (TO_EN) g = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b0001;
            else       g = 4'b0001;
            sb.push_back(expv(g, (g == 4'b0010) ? 2'd1 : 2'd0, 1'b1));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL timeout[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic       r_rst;
        logic       r_rel;
        logic       rel_c;
        logic [3:0] r_req;
        logic [3:0] masked;
        int         k;
        drive(1'b1, 4'b0000, 1'b0);
        step();
        m_busy = 1'b0;
        m_sel  = 2'd0;
        m_ptr  = 0;
        m_hold = 0;
        for (int i = 0; i < 200; i++) begin
            r_rst = ($urandom_range(0, 40) == 0);
            r_rel = ($urandom_range(0, 3) == 0);
            r_req = 4'($urandom_range(0, 15));
            // Usually keep the owner requesting so grants last several cycles
            if (m_busy && $urandom_range(0, 3) != 0) r_req[m_sel] = 1'b1;
            drive(r_rst, r_req, r_rel);
            if (r_rst) begin
                m_busy = 1'b0;
                m_sel  = 2'd0;
                m_ptr  = 0;
                m_hold = 0;
            end else if (m_busy) begin
                rel_c = r_rel || !r_req[m_sel] || (TO_EN && m_hold == int'(MAX_HOLD));
                if (!rel_c) begin
                    m_hold++;
                end else begin
                    masked        = r_req;
                    masked[m_sel] = 1'b0;
                    k             = pick(masked, m_ptr);
                    if (k < 0) begin
                        m_busy = 1'b0;
                    end else begin
                        m_sel  = 2'(k);
                        m_ptr  = (k + 1) % 4;
                        m_hold = 0;
                    end
                end
            end else begin
                k = pick(r_req, m_ptr);
                if (k >= 0) begin
                    m_busy = 1'b1;
                    m_sel  = 2'(k);
                    m_ptr  = (k + 1) % 4;
                    m_hold = 0;
                end
            end
            sb.push_back(expv(m_busy ? (4'b0001 << m_sel) : 4'b0000, m_sel, m_busy));
            step();
            got  = {bus.gnt, bus.sel, bus.busy, bus.out};
            want = sb.pop_front();
            n_total++;
            if (got !== want)
                $display("FAIL random[%0d]: got gnt=%b sel=%0d busy=%b out=%h, want gnt=%b sel=%0d busy=%b out=%h",
                         i, got[14:11], got[10:9], got[8], got[7:0],
                         want[14:11], want[10:9], want[8], want[7:0]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.in = IN_WORD;
        drive(1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        test_reset();
        test_rotation();
        test_single();
        test_handoff();
        test_rel_same();
        test_mid_reset();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
